// File: rtl/bram_vector_loader.sv
// ----------------------------------------------------------------------------
// bram_vector_loader
//   Read-side sequencer for the two-port activation BRAM. It fetches a
//   contiguous run of activation words and packs them into one wide vector.
//   The vector is offered to the layer datapath with a valid/ready handshake.
//   The sequencer absorbs the BRAM's one-cycle registered read latency.
//
//   Optional build macro: VECTOR_LOADER_SINGLE_PORT_EN
//     Defined   : only port 0 is used, one word per READ cycle. Port 1 is
//                 held idle so a concurrent agent can use it.
//     Undefined : both ports read in parallel, two words per READ cycle.
// ----------------------------------------------------------------------------
module bram_vector_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NEURONS    = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [LEN_WIDTH-1:0]            length,
    output logic                            busy,
    output logic                            readEnable0,
    output logic [ADDR_WIDTH-1:0]           readAddress0,
    input  logic [DATA_WIDTH-1:0]           readData0,
    output logic                            readEnable1,
    output logic [ADDR_WIDTH-1:0]           readAddress1,
    input  logic [DATA_WIDTH-1:0]           readData1,
    output logic [NEURONS*DATA_WIDTH-1:0]   vector_out,
    output logic                            vector_valid,
    input  logic                            vector_ready
);

    // Slot indices need one bit more than the length so that "2k+1" and
    // "2k+2" never overflow when compared against the latched length.
    localparam int SLOT_W = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_next_state;

    logic [ADDR_WIDTH-1:0]           r_base;
    logic [LEN_WIDTH-1:0]            r_len;
    logic [LEN_WIDTH-1:0]            r_issue;

    // A pending flag plus slot index per port carries each issued read
    // across the BRAM latency to the edge where its data is captured.
    logic                            r_pend0;
    logic                            r_pend1;
    logic [SLOT_W-1:0]               r_slot0;
    logic [SLOT_W-1:0]               r_slot1;

    logic [NEURONS*DATA_WIDTH-1:0]   r_vec;

    logic [LEN_WIDTH-1:0]            w_len_clamped;
    logic [SLOT_W-1:0]               w_slot0;
    logic [SLOT_W-1:0]               w_slot1;
    logic                            w_last_issue;
    logic                            w_en0;
    logic                            w_en1;
    logic [ADDR_WIDTH-1:0]           w_addr0;
    logic [ADDR_WIDTH-1:0]           w_addr1;
    logic                            w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    // Clamp the requested length to the vector capacity.
    always_comb begin
        w_len_clamped = length;
        if (length > LEN_WIDTH'(NEURONS)) begin
            w_len_clamped = LEN_WIDTH'(NEURONS);
        end else begin
            w_len_clamped = length;
        end
    end

    // Derive slot indices, read enables and addresses from the issue counter.
    always_comb begin
        w_slot0      = '0;
        w_slot1      = '0;
        w_last_issue = 1'b0;
        w_en0        = 1'b0;
        w_en1        = 1'b0;
        w_addr0      = '0;
        w_addr1      = '0;
`ifdef VECTOR_LOADER_SINGLE_PORT_EN
        w_slot0      = {1'b0, r_issue};
        w_slot1      = '0;
        w_last_issue = (w_slot0 + SLOT_W'(1)) >= {1'b0, r_len};
`else
        w_slot0      = {r_issue, 1'b0};
        w_slot1      = {r_issue, 1'b1};
        w_last_issue = (w_slot0 + SLOT_W'(2)) >= {1'b0, r_len};
`endif
        if (r_state == S_READ) begin
            w_en0   = 1'b1;
            w_addr0 = r_base + ADDR_WIDTH'(w_slot0);
`ifndef VECTOR_LOADER_SINGLE_PORT_EN
            // The odd slot is read only while it lies inside the requested run.
            if (w_slot1 < {1'b0, r_len}) begin
                w_en1   = 1'b1;
                w_addr1 = r_base + ADDR_WIDTH'(w_slot1);
            end else begin
                w_en1   = 1'b0;
                w_addr1 = '0;
            end
`endif
        end else begin
            w_en0   = 1'b0;
            w_addr0 = '0;
        end
    end

    // Compute the next sequencer state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_clamped == '0) begin
                        w_next_state = S_VALID;
                    end else begin
                        w_next_state = S_READ;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ: begin
                if (w_last_issue) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_state = S_READ;
                end
            end
            S_DRAIN: begin
                w_next_state = S_VALID;
            end
            S_VALID: begin
                if (vector_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_VALID;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the request and advance the issue counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_base  <= '0;
            r_len   <= '0;
            r_issue <= '0;
        end else if (w_accept) begin
            r_base  <= base_addr;
            r_len   <= w_len_clamped;
            r_issue <= '0;
        end else if (r_state == S_READ) begin
            r_issue <= r_issue + LEN_WIDTH'(1);
        end
    end

    // Remember which slot each issued read belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_pend0 <= w_en0;
            r_pend1 <= w_en1;
            r_slot0 <= w_en0 ? w_slot0 : '0;
            r_slot1 <= w_en1 ? w_slot1 : '0;
        end
    end

    // Clear the vector on an accepted start and capture returning read data.
    // A capture never coincides with an accepted start, because pending
    // flags are only ever set in READ and drain one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vec <= '0;
        end else if (w_accept) begin
            r_vec <= '0;
        end else begin
            for (int i = 0; i < NEURONS; i++) begin
                if (r_pend0 && (r_slot0 == SLOT_W'(i))) begin
                    r_vec[i*DATA_WIDTH +: DATA_WIDTH] <= readData0;
                end
                if (r_pend1 && (r_slot1 == SLOT_W'(i))) begin
                    r_vec[i*DATA_WIDTH +: DATA_WIDTH] <= readData1;
                end
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign vector_valid = (r_state == S_VALID);
    assign vector_out   = r_vec;
    assign readEnable0  = w_en0;
    assign readAddress0 = w_addr0;
    assign readEnable1  = w_en1;
    assign readAddress1 = w_addr1;

endmodule
